// File: rtl/arbitro_pkg.sv
// Shared types and helpers for the four-source TLP arbiter.
package arbitro_pkg;

    localparam int NUM_SRC     = 4;
    localparam int SRC_W       = 2;
    localparam int MASK_CYCLES = 2;
    localparam int MASK_W      = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SERVE = 2'd1,
        STALL = 2'd2
    } state_e;

    // Next source index in round-robin order; wraps 3 -> 0 by width.
    function automatic logic [SRC_W-1:0] rr_inc(input logic [SRC_W-1:0] idx);
        return idx + 2'd1;
    endfunction

    function automatic logic [SRC_W-1:0] onehot_to_idx(input logic [NUM_SRC-1:0] oh);
        logic [SRC_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (oh[i]) begin
                idx = SRC_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/arbitro_sel.sv
// Combinational grant selection: urgent (almost_full) sources first, lowest index
// wins; otherwise round-robin starting just after rr_ptr.
module arbitro_sel
    import arbitro_pkg::*;
(
    input  logic [NUM_SRC-1:0] eligible,
    input  logic [NUM_SRC-1:0] urgent,
    input  logic [SRC_W-1:0]   rr_ptr,
    output logic [NUM_SRC-1:0] grant,
    output logic               grant_vld
);

    logic [NUM_SRC-1:0] urgent_elig;
    logic [SRC_W-1:0]   idx;
    logic               found;

    // NOTE: every variable gets a default at the top of always_comb so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        urgent_elig = eligible & urgent;
        grant       = '0;
        found       = 1'b0;
        idx         = rr_ptr;

        for (int i = 0; i < NUM_SRC; i++) begin
            if (!found && urgent_elig[i]) begin
                grant[i] = 1'b1;
                found    = 1'b1;
            end
        end

        for (int k = 0; k < NUM_SRC; k++) begin
            idx = rr_inc(idx);
            if (!found && eligible[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end

        grant_vld = found;
    end

endmodule

// File: rtl/arbitro_tlp.sv
// Four-to-one TLP arbiter: pops at most one source FIFO per cycle, registers the
// returned word and pushes it downstream with its source tag two cycles later.
module arbitro_tlp #(
    parameter int DATA_W  = 4,
    parameter int NUM_SRC = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_SRC*DATA_W-1:0] data_in,
    input  logic [NUM_SRC-1:0]        empty_in,
    input  logic [NUM_SRC-1:0]        almost_full_in,
    output logic [NUM_SRC-1:0]        pop,
    input  logic                      out_full,
    input  logic                      out_almost_full,
    output logic                      push,
    output logic [DATA_W-1:0]         data_out,
    output logic [1:0]                src_id,
    output logic                      idle
);

    import arbitro_pkg::*;

    state_e              state_q, state_d;
    logic [SRC_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [MASK_W-1:0]   mask_cnt_q [NUM_SRC];
    logic [MASK_W-1:0]   mask_cnt_d [NUM_SRC];
    logic [NUM_SRC-1:0]  pop_q, pop_d;
    logic                rd_vld_q, rd_vld_d;
    logic [SRC_W-1:0]    rd_src_q, rd_src_d;
    logic                push_q, push_d;
    logic [DATA_W-1:0]   data_out_q, data_out_d;
    logic [SRC_W-1:0]    src_id_q, src_id_d;

    logic [DATA_W-1:0]   src_data [NUM_SRC];
    logic [NUM_SRC-1:0]  eligible;
    logic [NUM_SRC-1:0]  grant;
    logic                grant_vld;
    logic                blocked;
    logic                do_grant;

    // A source's flags are stale for two cycles after its grant, so it is
    // held out of arbitration until its mask counter drains.
    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            src_data[i] = data_in[i*DATA_W +: DATA_W];
            eligible[i] = !empty_in[i] && (mask_cnt_q[i] == '0);
        end
    end

    assign blocked = out_full | out_almost_full;

    arbitro_sel u_sel (
        .eligible  (eligible),
        .urgent    (almost_full_in),
        .rr_ptr    (rr_ptr_q),
        .grant     (grant),
        .grant_vld (grant_vld)
    );

    always_comb begin
        state_d  = state_q;
        do_grant = 1'b0;

        case (state_q)
            IDLE: begin
                if (grant_vld && !blocked) begin
                    state_d  = SERVE;
                    do_grant = 1'b1;
                end
            end
            SERVE: begin
                if (blocked) begin
                    state_d = STALL;
                end else if (!grant_vld) begin
                    state_d = IDLE;
                end else begin
                    do_grant = 1'b1;
                end
            end
            STALL: begin
                if (!blocked) begin
                    state_d = SERVE;
                end
            end
            default: state_d = IDLE;
        endcase

        pop_d    = do_grant ? grant : '0;
        rr_ptr_d = do_grant ? onehot_to_idx(grant) : rr_ptr_q;

        for (int i = 0; i < NUM_SRC; i++) begin
            if (do_grant && grant[i]) begin
                mask_cnt_d[i] = MASK_W'(MASK_CYCLES);
            end else if (mask_cnt_q[i] != '0) begin
                mask_cnt_d[i] = mask_cnt_q[i] - MASK_W'(1);
            end else begin
                mask_cnt_d[i] = '0;
            end
        end

        // FIFO read data is valid the cycle after the pop; capture it then.
        rd_vld_d   = |pop_q;
        rd_src_d   = onehot_to_idx(pop_q);
        push_d     = rd_vld_q;
        data_out_d = rd_vld_q ? src_data[rd_src_q] : data_out_q;
        src_id_d   = rd_vld_q ? rd_src_q : src_id_q;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its _d value from before the edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            rr_ptr_q   <= SRC_W'(NUM_SRC - 1);
            pop_q      <= '0;
            rd_vld_q   <= 1'b0;
            rd_src_q   <= '0;
            push_q     <= 1'b0;
            // NOTE: the data pipeline is reset along with control, so words in
            // flight at reset are dropped and the outputs read back as zero.
            data_out_q <= '0;
            src_id_q   <= '0;
            for (int i = 0; i < NUM_SRC; i++) begin
                mask_cnt_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            pop_q      <= pop_d;
            rd_vld_q   <= rd_vld_d;
            rd_src_q   <= rd_src_d;
            push_q     <= push_d;
            data_out_q <= data_out_d;
            src_id_q   <= src_id_d;
            for (int i = 0; i < NUM_SRC; i++) begin
                mask_cnt_q[i] <= mask_cnt_d[i];
            end
        end
    end

    assign pop      = pop_q;
    assign push     = push_q;
    assign data_out = data_out_q;
    assign src_id   = src_id_q;
    assign idle     = (state_q == IDLE);

endmodule

// File: tb/tb_arbitro_tlp.sv
// Directed bench for arbitro_tlp: a per-cycle vector table plus FIFO-model
// sequences for draining, back-pressure and data ordering.
module tb_arbitro_tlp;

    localparam int DATA_W  = 4;
    localparam int NUM_SRC = 4;

    logic                      clk = 1'b0;
    logic                      reset;
    logic [NUM_SRC*DATA_W-1:0] data_in;
    logic [NUM_SRC-1:0]        empty_in;
    logic [NUM_SRC-1:0]        almost_full_in;
    logic [NUM_SRC-1:0]        pop;
    logic                      out_full;
    logic                      out_almost_full;
    logic                      push;
    logic [DATA_W-1:0]         data_out;
    logic [1:0]                src_id;
    logic                      idle;

    always #5 clk = ~clk;

    arbitro_tlp #(.DATA_W(DATA_W), .NUM_SRC(NUM_SRC)) dut (
        .clk             (clk),
        .reset           (reset),
        .data_in         (data_in),
        .empty_in        (empty_in),
        .almost_full_in  (almost_full_in),
        .pop             (pop),
        .out_full        (out_full),
        .out_almost_full (out_almost_full),
        .push            (push),
        .data_out        (data_out),
        .src_id          (src_id),
        .idle            (idle)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct packed {
        logic       rst;
        logic [3:0] empty;
        logic [3:0] af;
        logic [3:0] pop;
        logic       push;
        logic [1:0] src;
        logic [3:0] dout;
        logic       idle;
    } vec_t;

    vec_t vt [21];

    // ---------------- source FIFO model ----------------
    typedef struct packed {
        logic [1:0]        src;
        logic [DATA_W-1:0] data;
    } exp_t;

    logic [DATA_W-1:0] fmem [NUM_SRC][8];
    int                frd  [NUM_SRC];
    int                fcnt [NUM_SRC];
    logic [DATA_W-1:0] rd_data [NUM_SRC];
    exp_t              exp_q[$];
    int                pop_log[$];
    int                push_cycles[$];
    int                cyc = 0;

    task automatic drive_model_outputs(input logic [NUM_SRC-1:0] emp);
        empty_in = emp;
        for (int i = 0; i < NUM_SRC; i++) begin
            data_in[i*DATA_W +: DATA_W] = rd_data[i];
        end
    endtask

    task automatic model_reset(input int words);
        logic [NUM_SRC-1:0] emp;
        reset = 1'b1;
        out_full = 1'b0;
        out_almost_full = 1'b0;
        almost_full_in = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            for (int j = 0; j < 8; j++) begin
                fmem[i][j] = {i[1:0], j[1:0]};
            end
            frd[i]     = 0;
            fcnt[i]    = words;
            rd_data[i] = '0;
            emp[i]     = (words == 0);
        end
        exp_q.delete();
        pop_log.delete();
        push_cycles.delete();
        drive_model_outputs(emp);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
    endtask

    // Observe the current cycle, then advance one clock and update the FIFOs.
    task automatic model_cycle();
        logic [NUM_SRC-1:0] p;
        logic [NUM_SRC-1:0] new_empty;
        exp_t e;
        int idx;
        p = pop;
        if (push === 1'b1) begin
            push_cycles.push_back(cyc);
            check("push_has_source", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("push_src", src_id, e.src);
                check("push_data", data_out, e.data);
            end
        end
        if (p != '0) begin
            idx = 0;
            for (int i = 0; i < NUM_SRC; i++) begin
                if (p[i]) idx = i;
            end
            check("pop_onehot", $countones(p), 1);
            check("pop_not_empty", 32'(fcnt[idx] > 0), 1);
            pop_log.push_back(idx);
            if (fcnt[idx] > 0) begin
                e.src  = idx[1:0];
                e.data = fmem[idx][frd[idx]];
                exp_q.push_back(e);
            end
        end
        for (int i = 0; i < NUM_SRC; i++) begin
            new_empty[i] = (fcnt[i] == 0);
        end
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (p[i] && fcnt[i] > 0) begin
                rd_data[i] = fmem[i][frd[i]];
                frd[i]++;
                fcnt[i]--;
            end
        end
        drive_model_outputs(new_empty);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        //            rst  empty    af       pop     push src   dout  idle
        vt[0]  = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0, 4'h0, 1'b1};
        vt[1]  = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0, 4'h0, 1'b1};
        vt[2]  = '{1'b0, 4'b0000, 4'b0000, 4'b0001, 1'b0, 2'd0, 4'h0, 1'b0};
        vt[3]  = '{1'b0, 4'b0000, 4'b0000, 4'b0010, 1'b0, 2'd0, 4'h0, 1'b0};
        vt[4]  = '{1'b0, 4'b0000, 4'b0000, 4'b0100, 1'b1, 2'd0, 4'hA, 1'b0};
        vt[5]  = '{1'b0, 4'b0000, 4'b0000, 4'b1000, 1'b1, 2'd1, 4'h5, 1'b0};
        vt[6]  = '{1'b1, 4'b0000, 4'b0000, 4'b0001, 1'b1, 2'd2, 4'hC, 1'b0};
        vt[7]  = '{1'b0, 4'b1111, 4'b0000, 4'b0000, 1'b0, 2'd0, 4'h0, 1'b1};
        vt[8]  = '{1'b0, 4'b1011, 4'b0000, 4'b0000, 1'b0, 2'd0, 4'h0, 1'b1};
        vt[9]  = '{1'b0, 4'b1011, 4'b0000, 4'b0100, 1'b0, 2'd0, 4'h0, 1'b0};
        vt[10] = '{1'b0, 4'b1011, 4'b0000, 4'b0000, 1'b0, 2'd0, 4'h0, 1'b1};
        vt[11] = '{1'b0, 4'b1111, 4'b0000, 4'b0000, 1'b1, 2'd2, 4'hC, 1'b1};
        vt[12] = '{1'b0, 4'b1111, 4'b0000, 4'b0000, 1'b0, 2'd2, 4'hC, 1'b1};
        vt[13] = '{1'b0, 4'b0000, 4'b1010, 4'b0000, 1'b0, 2'd2, 4'hC, 1'b1};
        vt[14] = '{1'b0, 4'b0000, 4'b1010, 4'b0010, 1'b0, 2'd2, 4'hC, 1'b0};
        vt[15] = '{1'b0, 4'b0000, 4'b1010, 4'b1000, 1'b0, 2'd2, 4'hC, 1'b0};
        vt[16] = '{1'b0, 4'b0000, 4'b1010, 4'b0001, 1'b1, 2'd1, 4'h5, 1'b0};
        vt[17] = '{1'b0, 4'b1111, 4'b0000, 4'b0010, 1'b1, 2'd3, 4'h3, 1'b0};
        vt[18] = '{1'b0, 4'b1111, 4'b0000, 4'b0000, 1'b1, 2'd0, 4'hA, 1'b1};
        vt[19] = '{1'b0, 4'b1111, 4'b0000, 4'b0000, 1'b1, 2'd1, 4'h5, 1'b1};
        vt[20] = '{1'b0, 4'b1111, 4'b0000, 4'b0000, 1'b0, 2'd1, 4'h5, 1'b1};

        reset           = 1'b1;
        empty_in        = 4'b0000;
        almost_full_in  = 4'b0000;
        out_full        = 1'b0;
        out_almost_full = 1'b0;
        data_in         = {4'h3, 4'hC, 4'h5, 4'hA};

        // Entry k: outputs expected in cycle k, inputs driven during cycle k.
        for (int k = 0; k < 21; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_pop", k),  pop,      vt[k].pop);
            check($sformatf("vec%0d_push", k), push,     vt[k].push);
            check($sformatf("vec%0d_src", k),  src_id,   vt[k].src);
            check($sformatf("vec%0d_dout", k), data_out, vt[k].dout);
            check($sformatf("vec%0d_idle", k), idle,     vt[k].idle);
            reset          = vt[k].rst;
            empty_in       = vt[k].empty;
            almost_full_in = vt[k].af;
        end

        // Four sources with three words each: strict 0,1,2,3 rotation, 12
        // back-to-back pushes, per-source order preserved.
        model_reset(3);
        for (int g = 0; g < 40 && !(push_cycles.size() >= 12 && exp_q.size() == 0); g++) begin
            model_cycle();
        end
        repeat (4) model_cycle();
        check("drain_pop_count", pop_log.size(), 12);
        check("drain_push_count", push_cycles.size(), 12);
        if (pop_log.size() == 12) begin
            for (int k = 0; k < 12; k++) begin
                check($sformatf("drain_order%0d", k), pop_log[k], k % 4);
            end
        end
        if (push_cycles.size() == 12) begin
            check("drain_push_span", push_cycles[11] - push_cycles[0], 11);
        end
        check("drain_idle", idle, 1);

        // Back-pressure: in-flight words complete, pops stop, then resume.
        model_reset(4);
        repeat (6) model_cycle();
        check("bp_pre_pop_active", 32'(pop != 0), 1);
        out_almost_full = 1'b1;
        model_cycle();
        check("bp_n1_pop", pop, 0);
        check("bp_n1_push", push, 1);
        model_cycle();
        check("bp_n2_pop", pop, 0);
        check("bp_n2_push", push, 1);
        model_cycle();
        check("bp_n3_pop", pop, 0);
        check("bp_n3_push", push, 0);
        model_cycle();
        check("bp_n4_pop", pop, 0);
        check("bp_n4_idle", idle, 0);
        out_almost_full = 1'b0;
        model_cycle();
        check("bp_f1_pop", pop, 0);
        model_cycle();
        check("bp_f2_pop_resumed", 32'(pop != 0), 1);
        out_full = 1'b1;
        model_cycle();
        check("full_g1_pop", pop, 0);
        out_full = 1'b0;
        for (int g = 0; g < 100 && (pop_log.size() < 16 || exp_q.size() != 0); g++) begin
            model_cycle();
        end
        repeat (4) model_cycle();
        check("bp_total_pops", pop_log.size(), 16);
        check("bp_scoreboard_empty", exp_q.size(), 0);
        check("bp_final_idle", idle, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
